// File: rtl/pwm_channel_bank.sv
// Bank of CHANNELS PWM comparators driven by a shared prescaled period counter.
// On/off settings are double-buffered so updates can land glitch-free at period wrap.
module pwm_channel_bank #(
  parameter int CHANNELS     = 16,
  parameter int WIDTH        = 12,
  parameter int PRESCALE_MIN = 3
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [7:0]                                        prescale_i,
  input  logic                                              sleep_i,
  input  logic                                              invert_i,
  input  logic                                              out_en_i,
  input  logic                                              update_mode_i,
  input  logic                                              write_enable_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] write_channel_i,
  input  logic [WIDTH-1:0]                                  write_on_i,
  input  logic [WIDTH-1:0]                                  write_off_i,
  input  logic                                              write_full_on_i,
  input  logic                                              write_full_off_i,
  output logic [CHANNELS-1:0]                               pwm_o,
  output logic [WIDTH-1:0]                                  counter_o,
  output logic                                              period_tick_o
);

  localparam int            CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW:0]   CH_LIM = (CW + 1)'(CHANNELS);
  localparam logic [7:0]    PMIN   = 8'(PRESCALE_MIN);

  logic [7:0]          pre_cnt;
  logic [7:0]          p_eff;
  logic                step;
  logic                wrap;
  logic                wr_ok;
  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] level;

  logic [WIDTH-1:0]    act_on   [CHANNELS];
  logic [WIDTH-1:0]    act_off  [CHANNELS];
  logic [WIDTH-1:0]    pend_on  [CHANNELS];
  logic [WIDTH-1:0]    pend_off [CHANNELS];
  logic [CHANNELS-1:0] act_fon;
  logic [CHANNELS-1:0] act_foff;
  logic [CHANNELS-1:0] pend_fon;
  logic [CHANNELS-1:0] pend_foff;
  logic [CHANNELS-1:0] pend_valid;

  // Live prescale_i is compared with >= so lowering it below pre_cnt wraps next cycle.
  always_comb begin
    p_eff = (prescale_i < PMIN) ? PMIN : prescale_i;
    step  = !sleep_i && (pre_cnt >= p_eff);
    wrap  = step && (counter_o == '1);
    wr_ok = write_enable_i && ({1'b0, write_channel_i} < CH_LIM);
    wr_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = wr_ok && (write_channel_i == CW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt       <= '0;
      counter_o     <= '0;
      period_tick_o <= 1'b0;
    end else if (sleep_i) begin
      pre_cnt       <= '0;
      counter_o     <= '0;
      period_tick_o <= 1'b0;
    end else if (step) begin
      pre_cnt       <= '0;
      counter_o     <= counter_o + 1'b1;
      period_tick_o <= wrap;
    end else begin
      pre_cnt       <= pre_cnt + 8'd1;
      period_tick_o <= 1'b0;
    end
  end

  // A write on the wrap cycle is assigned after the transfer, so it wins and stays pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        act_on[i]   <= '0;
        act_off[i]  <= '0;
        pend_on[i]  <= '0;
        pend_off[i] <= '0;
      end
      act_fon    <= '0;
      act_foff   <= '1;
      pend_fon   <= '0;
      pend_foff  <= '1;
      pend_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wrap && pend_valid[i]) begin
          act_on[i]     <= pend_on[i];
          act_off[i]    <= pend_off[i];
          act_fon[i]    <= pend_fon[i];
          act_foff[i]   <= pend_foff[i];
          pend_valid[i] <= 1'b0;
        end
        if (wr_sel[i]) begin
          pend_on[i]   <= write_on_i;
          pend_off[i]  <= write_off_i;
          pend_fon[i]  <= write_full_on_i;
          pend_foff[i] <= write_full_off_i;
          if (update_mode_i) begin
            act_on[i]     <= write_on_i;
            act_off[i]    <= write_off_i;
            act_fon[i]    <= write_full_on_i;
            act_foff[i]   <= write_full_off_i;
            pend_valid[i] <= 1'b0;
          end else begin
            pend_valid[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    level = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (act_foff[i])                 level[i] = 1'b0;
      else if (act_fon[i])             level[i] = 1'b1;
      else if (act_on[i] == act_off[i]) level[i] = 1'b0;
      else if (act_on[i] < act_off[i])
        level[i] = (counter_o >= act_on[i]) && (counter_o < act_off[i]);
      else
        level[i] = (counter_o >= act_on[i]) || (counter_o < act_off[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_o <= '0;
    else         pwm_o <= out_en_i ? (level ^ {CHANNELS{invert_i}}) : '0;
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Randomised and directed bench for pwm_channel_bank against a cycle-level reference model.
module tb_pwm_channel_bank;

  localparam int CH   = 12;
  localparam int W    = 8;
  localparam int PMIN = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    prescale;
  logic          sleep, invert, out_en, upd_mode, we;
  logic [CW-1:0] wch;
  logic [W-1:0]  won, woff;
  logic          wfon, wfoff;
  logic [CH-1:0] pwm;
  logic [W-1:0]  counter;
  logic          tick;

  int errors = 0;
  int checks = 0;

  pwm_channel_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_MIN(PMIN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .prescale_i(prescale), .sleep_i(sleep),
    .invert_i(invert), .out_en_i(out_en), .update_mode_i(upd_mode),
    .write_enable_i(we), .write_channel_i(wch), .write_on_i(won),
    .write_off_i(woff), .write_full_on_i(wfon), .write_full_off_i(wfoff),
    .pwm_o(pwm), .counter_o(counter), .period_tick_o(tick)
  );

  always #5 clk = ~clk;

  // Reference model: settings per channel, counter as plain integers.
  int m_pre, m_cnt;
  bit m_tick;
  bit [CH-1:0] m_pwm;
  int a_on[CH], a_off[CH], p_on[CH], p_off[CH];
  bit a_fon[CH], a_foff[CH], p_fon[CH], p_foff[CH], p_v[CH];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_level(int on, int off, bit fon, bit foff, int c);
    if (foff) return 1'b0;
    if (fon) return 1'b1;
    if (on == off) return 1'b0;
    if (on < off) return (c >= on) && (c < off);
    return !((c >= off) && (c < on));
  endfunction

  function automatic int peff();
    return (int'(prescale) < PMIN) ? PMIN : int'(prescale);
  endfunction

  function automatic bit wrap_next();
    return !sleep && (m_pre >= peff()) && (m_cnt == MAXC);
  endfunction

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_tick = 0; m_pwm = '0;
    for (int i = 0; i < CH; i++) begin
      a_on[i] = 0; a_off[i] = 0; p_on[i] = 0; p_off[i] = 0;
      a_fon[i] = 0; a_foff[i] = 1; p_fon[i] = 0; p_foff[i] = 1; p_v[i] = 0;
    end
  endtask

  task automatic model_clock();
    bit wrapped;
    wrapped = 0;
    for (int i = 0; i < CH; i++)
      m_pwm[i] = out_en ? (ref_level(a_on[i], a_off[i], a_fon[i], a_foff[i], m_cnt) ^ invert) : 1'b0;
    if (sleep) begin
      m_pre = 0; m_cnt = 0; m_tick = 0;
    end else if (m_pre >= peff()) begin
      wrapped = (m_cnt == MAXC);
      m_pre = 0; m_cnt = (m_cnt + 1) % (MAXC + 1); m_tick = wrapped;
    end else begin
      m_pre++; m_tick = 0;
    end
    if (wrapped)
      for (int i = 0; i < CH; i++)
        if (p_v[i]) begin
          a_on[i] = p_on[i]; a_off[i] = p_off[i]; a_fon[i] = p_fon[i]; a_foff[i] = p_foff[i];
          p_v[i] = 0;
        end
    if (we && int'(wch) < CH) begin
      p_on[wch] = won; p_off[wch] = woff; p_fon[wch] = wfon; p_foff[wch] = wfoff;
      if (upd_mode) begin
        a_on[wch] = won; a_off[wch] = woff; a_fon[wch] = wfon; a_foff[wch] = wfoff;
        p_v[wch] = 0;
      end else p_v[wch] = 1;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_val("counter", counter, m_cnt);
    check_val("tick", tick, m_tick);
    check_val("pwm", pwm, m_pwm);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int on, input int off, input bit fon, input bit foff, input bit mode);
    wch = CW'(ch); won = W'(on); woff = W'(off); wfon = fon; wfoff = foff; upd_mode = mode; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  // Steps until the next clock edge is a wrap; a missing wrap counts as a failure.
  task automatic run_to_wrap_edge();
    for (int k = 0; k < 4000; k++) begin
      if (wrap_next()) return;
      step();
    end
    check_val("wrap_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; prescale = 8'd3; sleep = 0; invert = 0; out_en = 1; upd_mode = 1;
    we = 0; wch = '0; won = '0; woff = '0; wfon = 0; wfoff = 0;
    model_reset();
    #1;
    check_val("reset_counter", counter, 0);
    check_val("reset_tick", tick, 0);
    check_val("reset_pwm", pwm, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Counter cadence and first full period with default full_off outputs.
    run(8);
    check_val("step4_count", counter, 2);
    run_to_wrap_edge();
    step();
    check_val("wrap_tick", tick, 1);
    check_val("wrap_count", counter, 0);

    // Immediate-mode 50% and wrap-around windows, then equal on/off.
    wr(0, 0, 'h80, 0, 0, 1);
    step();
    check_val("ch0_high_at_0", pwm[0], 1);
    wr(3, 'hC0, 'h40, 0, 0, 1);
    run(1100);
    invert = 1;
    run(1100);
    invert = 0;
    wr(3, 'h10, 'h10, 0, 0, 1);
    run(300);

    // Deferred update written mid-period, then a write landing exactly on the wrap.
    run(200);
    wr(5, 0, 'h10, 0, 0, 0);
    run(20);
    check_val("ch5_deferred", pwm[5], 0);
    run_to_wrap_edge();
    step();
    check_val("ch5_at_tick", pwm[5], 0);
    step();
    check_val("ch5_after_tick", pwm[5], 1);
    run_to_wrap_edge();
    wr(5, 0, 0, 0, 1, 0);
    step();
    check_val("ch5_wrap_write_held", pwm[5], 1);
    run(1100);

    // Overrides, output enable, invalid channel.
    wr(7, 0, 'h40, 1, 1, 1);
    run(2);
    check_val("fon_foff_low", pwm[7], 0);
    wr(7, 0, 'h40, 1, 0, 1);
    run(300);
    out_en = 0; invert = 1;
    run(3);
    check_val("out_en_zero", pwm, 0);
    out_en = 1; invert = 0;
    wr(CH, 0, 'h80, 1, 0, 1);
    wr(CH + 2, 0, 'h80, 1, 0, 0);
    run(1100);

    // Prescale clamp, live lowering, sleep.
    prescale = 8'd0;
    run(300);
    prescale = 8'd9;
    run(50);
    prescale = 8'd4;
    run(50);
    sleep = 1;
    run(40);
    check_val("sleep_count", counter, 0);
    wr(9, 0, 'h10, 0, 0, 1);
    wr(10, 0, 'h10, 0, 0, 0);
    run(20);
    sleep = 0;
    run(1400);

    // Randomised traffic.
    for (int k = 0; k < 9000; k++) begin
      if ($urandom_range(15) == 0) begin
        wch = CW'($urandom_range(15)); won = W'($urandom); woff = W'($urandom);
        wfon = ($urandom_range(3) == 0); wfoff = ($urandom_range(3) == 0);
        upd_mode = $urandom_range(1); we = 1'b1;
      end
      if ($urandom_range(199) == 0) invert = ~invert;
      if ($urandom_range(299) == 0) out_en = ~out_en;
      if ($urandom_range(499) == 0) prescale = 8'($urandom_range(5));
      if ($urandom_range(399) == 0) sleep = ~sleep;
      step();
      we = 1'b0;
    end
    sleep = 0; out_en = 1;

    // Asynchronous reset in the middle of a period.
    run(37);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midreset_counter", counter, 0);
    check_val("midreset_tick", tick, 0);
    check_val("midreset_pwm", pwm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prescale = 8'd3;
    run(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Parametrised PWM engine for the LED controller: an integrated prescaled period counter plus CHANNELS independent on/off-count comparators with shadowed (glitch-free) register updates, full-on/full-off overrides, global invert, output-enable and sleep. It sits between `register_data` (which drives its write port) and the LED pins. It replaces the fixed 16-channel `prescaled_counter` + `pwm_driver` pair.

## Interface
Parameters:
- CHANNELS, 16, number of PWM outputs (1..64)
- WIDTH, 12, counter/compare width in bits
- PRESCALE_MIN, 3, lower clamp applied to prescale_i

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- prescale_i  in  8  prescaler terminal value; counter advances every (max(prescale_i,PRESCALE_MIN)+1) clocks
- sleep_i  in  1  1 = prescaler and counter held at 0, all channels idle
- invert_i  in  1  1 = invert every enabled pwm_o bit
- out_en_i  in  1  0 = force pwm_o to all-zero (applied after invert)
- update_mode_i  in  1  0 = writes take effect at period wrap, 1 = immediately
- write_enable_i  in  1  single-cycle write strobe
- write_channel_i  in  $clog2(CHANNELS) (min 1)  target channel
- write_on_i  in  WIDTH  count at which output rises
- write_off_i  in  WIDTH  count at which output falls
- write_full_on_i  in  1  force channel high
- write_full_off_i  in  1  force channel low (overrides full-on)
- pwm_o  out  CHANNELS  registered PWM outputs
- counter_o  out  WIDTH  current period count
- period_tick_o  out  1  one-cycle pulse on counter wrap

## Operation
- Prescaler: pre_cnt counts 0..P where P = max(prescale_i, PRESCALE_MIN); at pre_cnt >= P it returns to 0 and counter_o increments. Comparison uses live prescale_i; lowering it below pre_cnt causes wrap on the next cycle.
- counter_o wraps 2^WIDTH-1 -> 0; period_tick_o = 1 in the cycle the wrap is registered (counter_o becomes 0).
- Per channel: pending set {on, off, full_on, full_off} and active set. Write with write_channel_i >= CHANNELS is ignored.
- Mode 0: write loads pending and sets pending_valid. At wrap, every channel with pending_valid copies pending→active and clears pending_valid. Write coinciding with wrap: earlier pending transfers, new value stays pending until the next wrap.
- Mode 1: write loads pending and active in the same cycle; pending_valid is cleared.
- Channel level (from active, count c): full_off → 0; else full_on → 1; else on==off → 0; else on<off → (on <= c < off); else on>off → (c >= on or c < off).
- pwm_o[i] = out_en_i ? (level ^ invert_i) : 0.
- Sleep: pre_cnt, counter_o held at 0, no period_tick_o, pending transfers suspended (mode 1 writes still apply); pwm_o evaluated normally against c=0. Leaving sleep resumes counting from 0.
- Reset values: pre_cnt 0, counter_o 0, period_tick_o 0, pwm_o 0; all on/off 0, full_on 0, full_off 1, pending_valid 0.

## Timing
- pwm_o is registered: pwm_o at cycle t+1 reflects counter_o, active set and invert_i/out_en_i at cycle t (1-cycle latency).
- Mode 1 write at cycle t: active visible at t+1, pwm_o at t+2.
- Mode 0: new active values first apply to the count 0 cycle after wrap; pwm_o changes one cycle after period_tick_o.
- Period = 2^WIDTH × (P+1) clocks.
- Reset assert mid-period: all state returns to reset values immediately; first count after release starts at pre_cnt 0.

## Test plan
- Reset, out_en_i=1, prescale_i=3: pwm_o=0 (full_off default), counter_o increments every 4 clocks, period_tick_o every 16384 clocks.
- Mode 1, ch0 on=0x000 off=0x800: pwm_o[0] high for counts 0..0x7FF, low 0x800..0xFFF (50%); invert_i=1 gives complement.
- Mode 1, ch3 on=0xC00 off=0x400 (wrap-around): high for c>=0xC00 or c<0x400; on=off=0x100 → constant 0.
- Mode 0, ch5 on=0 off=0x100 written mid-period: pwm_o[5] unchanged until wrap, first high one cycle after period_tick_o; write on the wrap cycle deferred one full period.
- full_on=1 full_off=1 → 0; full_off cleared → constant 1; out_en_i=0 → pwm_o all zero regardless of invert_i; write_channel_i=CHANNELS ignored.
- prescale_i=0 → clamps to 3 (4-clock step); sleep_i=1 holds counter_o at 0, no ticks; rst_ni pulsed mid-period returns all outputs to reset values.
